mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and a single memory port.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment that drives the requests and the memory response.
interface mem_bus_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;

   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_ready;
   logic [31:0] dma_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic [1:0]  grant;
   logic        err;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ready, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack,
      output grant, err
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ready, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack,
      input  grant, err
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin memory bus arbiter with an access watchdog.
//
//  state | meaning
//  IDLE  | no access in flight; arbitrate between pending requests
//  BUSY  | access latched onto mem_*, waiting for mem_ack or watchdog expiry
//  DONE  | one-cycle ready (and err on abort) to the granted master
//
// All outputs are registered. A tie in IDLE goes to the master that was not
// served last; after reset the CPU counts as last served, so the DMA wins the
// first tie. An access that sees no mem_ack for TIMEOUT+1 BUSY cycles completes
// with ERR_DATA and err set; an ack on the expiry cycle still completes normally.
module mem_bus_arbiter #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input logic              clk,
   input logic              rst_n,
   mem_bus_arbiter_if.slave bus
);
   localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);
   localparam logic [1:0] G_NONE    = 2'b00;
   localparam logic [1:0] G_CPU     = 2'b01;
   localparam logic [1:0] G_DMA     = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_last_dma;
   logic [1:0]  r_grant;
   logic        r_mem_en;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_cpu_ready;
   logic        r_dma_ready;
   logic [31:0] r_cpu_rdata;
   logic [31:0] r_dma_rdata;
   logic        r_err;

   logic        w_pick_cpu;
   logic        w_pick_dma;
   logic        w_timeout;
   logic        w_finish;
   logic [31:0] w_rsp_data;

   // CPU wins a tie only when the DMA was served last.
   assign w_pick_cpu = bus.cpu_req && (!bus.dma_req || r_last_dma);
   assign w_pick_dma = bus.dma_req && !w_pick_cpu;
   assign w_timeout  = (r_cnt == L_TIMEOUT) && !bus.mem_ack;
   assign w_finish   = bus.mem_ack || w_timeout;
   assign w_rsp_data = bus.mem_ack ? bus.mem_rdata : ERR_DATA;

   // Arbitration FSM, access latching, watchdog counter and completion outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_last_dma  <= 1'b0;
         r_grant     <= G_NONE;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_cpu_ready <= 1'b0;
         r_dma_ready <= 1'b0;
         r_cpu_rdata <= 32'd0;
         r_dma_rdata <= 32'd0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick_cpu) begin
                  r_grant     <= G_CPU;
                  r_mem_we    <= bus.cpu_we;
                  r_mem_addr  <= bus.cpu_addr;
                  r_mem_wdata <= bus.cpu_wdata;
                  r_mem_en    <= 1'b1;
                  r_cnt       <= 8'd0;
                  r_state     <= S_BUSY;
               end else if (w_pick_dma) begin
                  r_grant     <= G_DMA;
                  r_mem_we    <= bus.dma_we;
                  r_mem_addr  <= bus.dma_addr;
                  r_mem_wdata <= bus.dma_wdata;
                  r_mem_en    <= 1'b1;
                  r_cnt       <= 8'd0;
                  r_state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_finish) begin
                  r_mem_en <= 1'b0;
                  r_err    <= !bus.mem_ack;
                  if (r_grant == G_DMA) begin
                     r_dma_ready <= 1'b1;
                     r_dma_rdata <= w_rsp_data;
                  end else begin
                     r_cpu_ready <= 1'b1;
                     r_cpu_rdata <= w_rsp_data;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_cpu_ready <= 1'b0;
               r_dma_ready <= 1'b0;
               r_err       <= 1'b0;
               r_last_dma  <= (r_grant == G_DMA);
               r_grant     <= G_NONE;
               r_state     <= S_IDLE;
            end
            default: begin
               r_grant     <= G_NONE;
               r_mem_en    <= 1'b0;
               r_cpu_ready <= 1'b0;
               r_dma_ready <= 1'b0;
               r_err       <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.grant     = r_grant;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.cpu_ready = r_cpu_ready;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dma_ready = r_dma_ready;
   assign bus.dma_rdata = r_dma_rdata;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences (tie alternation, reset mid-access) and randomized traffic against
// a transaction-level model of the arbitration and completion rules.
module tb_mem_bus_arbiter;
   localparam int          TIMEOUT  = 255;
   localparam logic [31:0] ERR_DATA = 32'h0000_0000;
   localparam int          NEVER    = 1000;

   typedef struct {
      logic        cpu_req;
      logic        cpu_we;
      logic [31:0] cpu_addr;
      logic [31:0] cpu_wdata;
      logic        dma_req;
      logic        dma_we;
      logic [31:0] dma_addr;
      logic [31:0] dma_wdata;
      int          ack_dly;
      logic [31:0] rd;
      logic [1:0]  exp_grant;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
   } vec_t;

   logic clk;
   logic rst_n;
   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model state: rdata each master should be holding, and who was served last
   logic [31:0] m_cpu_rdata;
   logic [31:0] m_dma_rdata;
   logic        m_last_dma;

   vec_t tbl [9];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic cr, input logic cw, input logic [31:0] ca,
                               input logic [31:0] cd, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd, input int dly,
                               input logic [31:0] rd, input logic [1:0] g);
      vec_t v;
      v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
      v.dma_req = dr; v.dma_we = dw; v.dma_addr = da; v.dma_wdata = dd;
      v.ack_dly = dly; v.rd = rd; v.exp_grant = g;
      v.exp_we    = (g == 2'b10) ? dw : cw;
      v.exp_addr  = (g == 2'b10) ? da : ca;
      v.exp_wdata = (g == 2'b10) ? dd : cd;
      return v;
   endfunction

   // grant must never name both masters
   always @(negedge clk) begin
      if (rst_n) check("grant_not_both", 32'(bus.grant == 2'b11), 32'd0);
   end

   task automatic drive_idle();
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
      bus.mem_ack = 0; bus.mem_rdata = 0;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst_n = 1'b0;
      tick();
      tick();
      m_cpu_rdata = 32'd0;
      m_dma_rdata = 32'd0;
      m_last_dma  = 1'b0;
      rst_n = 1'b1;
   endtask

   // One complete access, starting and ending in an IDLE cycle.
   task automatic do_access(input vec_t v);
      int   n_busy;
      int   bad;
      logic acked;
      logic win_dma;
      win_dma = (v.exp_grant == 2'b10);
      acked   = (v.ack_dly <= TIMEOUT);
      n_busy  = acked ? v.ack_dly + 1 : TIMEOUT + 1;
      bus.cpu_req = v.cpu_req; bus.cpu_we = v.cpu_we;
      bus.cpu_addr = v.cpu_addr; bus.cpu_wdata = v.cpu_wdata;
      bus.dma_req = v.dma_req; bus.dma_we = v.dma_we;
      bus.dma_addr = v.dma_addr; bus.dma_wdata = v.dma_wdata;
      bus.mem_ack = 0;
      tick();
      check("grant", 32'(bus.grant), 32'(v.exp_grant));
      check("mem_en_start", 32'(bus.mem_en), 32'd1);
      check("mem_addr", bus.mem_addr, v.exp_addr);
      check("mem_we", 32'(bus.mem_we), 32'(v.exp_we));
      check("mem_wdata", bus.mem_wdata, v.exp_wdata);
      bad = 0;
      for (int i = 0; i < n_busy; i++) begin
         if (!(bus.mem_en && bus.grant == v.exp_grant && bus.mem_addr == v.exp_addr &&
               bus.mem_we == v.exp_we && bus.mem_wdata == v.exp_wdata &&
               !bus.cpu_ready && !bus.dma_ready && !bus.err)) bad++;
         if (win_dma) begin
            bus.dma_addr = $urandom; bus.dma_wdata = $urandom; bus.dma_we = ~bus.dma_we;
         end else begin
            bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; bus.cpu_we = ~bus.cpu_we;
         end
         if (acked && i == n_busy - 1) begin
            bus.mem_ack = 1; bus.mem_rdata = v.rd;
         end else begin
            bus.mem_ack = 0; bus.mem_rdata = $urandom;
         end
         tick();
      end
      bus.mem_ack = 0;
      check("busy_hold_cycles_bad", 32'(bad), 32'd0);
      if (win_dma) m_dma_rdata = acked ? v.rd : ERR_DATA;
      else         m_cpu_rdata = acked ? v.rd : ERR_DATA;
      check("cpu_ready", 32'(bus.cpu_ready), 32'(!win_dma));
      check("dma_ready", 32'(bus.dma_ready), 32'(win_dma));
      check("cpu_rdata", bus.cpu_rdata, m_cpu_rdata);
      check("dma_rdata", bus.dma_rdata, m_dma_rdata);
      check("err", 32'(bus.err), 32'(!acked));
      check("mem_en_done", 32'(bus.mem_en), 32'd0);
      if (win_dma) bus.dma_req = 0; else bus.cpu_req = 0;
      tick();
      check("idle_ready", 32'({bus.cpu_ready, bus.dma_ready, bus.err}), 32'd0);
      check("idle_grant", 32'(bus.grant), 32'd0);
      check("idle_mem_en", 32'(bus.mem_en), 32'd0);
      m_last_dma = win_dma;
   endtask

   initial begin
      logic        c_pend, c_we, d_pend, d_we, win_dma;
      logic [31:0] c_addr, c_wd, d_addr, d_wd;
      int          r, dly;
      vec_t        v;

      //          cr cw cpu_addr       cpu_wdata     dr dw dma_addr       dma_wdata     dly    rd            grant
      tbl[0] = mk(1, 0, 32'h0000_0100, 32'h0,        0, 0, 32'h0,         32'h0,        0,     32'h1234_5678, 2'b01);
      tbl[1] = mk(1, 0, 32'h0000_0300, 32'h33,       1, 1, 32'h0000_0200, 32'hCAFE_F00D, 3,    32'h0BAD_0001, 2'b10);
      tbl[2] = mk(1, 0, 32'h0000_0300, 32'h33,       0, 0, 32'h0,         32'h0,        1,     32'h3030_3030, 2'b01);
      tbl[3] = mk(1, 1, 32'h0000_0500, 32'h5555_5555, 1, 0, 32'h0000_0400, 32'h0,       2,     32'h4444_0000, 2'b10);
      tbl[4] = mk(1, 1, 32'h0000_0500, 32'h5555_5555, 0, 0, 32'h0,        32'h0,        0,     32'h5A5A_5A5A, 2'b01);
      tbl[5] = mk(0, 0, 32'h0,         32'h0,        1, 0, 32'h0000_0600, 32'h0,        5,     32'h0000_0066, 2'b10);
      tbl[6] = mk(1, 0, 32'h0000_0700, 32'h0,        0, 0, 32'h0,         32'h0,        255,   32'hAAAA_5555, 2'b01);
      tbl[7] = mk(1, 0, 32'h0000_0800, 32'h0,        0, 0, 32'h0,         32'h0,        NEVER, 32'h1111_1111, 2'b01);
      tbl[8] = mk(0, 0, 32'h0,         32'h0,        1, 1, 32'h0000_0900, 32'h99,       0,     32'h9999_0000, 2'b10);

      apply_reset();
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_ready", 32'({bus.cpu_ready, bus.dma_ready, bus.err}), 32'd0);
      check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      check("rst_dma_rdata", bus.dma_rdata, 32'd0);

      for (int i = 0; i < 9; i++) do_access(tbl[i]);

      // both masters requesting from reset: strict alternation starting with DMA
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         v = mk(1, 0, 32'h1000 + 32'(i), 32'h0, 1, 0, 32'h2000 + 32'(i), 32'h0, 0,
                32'hD000_0000 + 32'(i), (i % 2 == 0) ? 2'b10 : 2'b01);
         do_access(v);
      end

      // reset in the middle of an access
      drive_idle();
      bus.cpu_req = 1; bus.cpu_addr = 32'h0000_0A00;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_mem_en", 32'(bus.mem_en), 32'd0);
      check("midrst_grant", 32'(bus.grant), 32'd0);
      bus.cpu_req = 0;
      tick();
      tick();
      m_cpu_rdata = 32'd0; m_dma_rdata = 32'd0; m_last_dma = 1'b0;
      rst_n = 1'b1;
      r = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.cpu_ready || bus.dma_ready || bus.mem_en || bus.grant != 2'b00) r++;
      end
      check("post_rst_quiet", 32'(r), 32'd0);
      do_access(mk(1, 0, 32'h0000_0B00, 32'h0, 1, 0, 32'h0000_0C00, 32'h0, 2,
                   32'hBBBB_0000, 2'b10));

      // randomized traffic against the transaction-level model
      c_pend = 0; d_pend = 0;
      c_we = 0; d_we = 0; c_addr = 0; c_wd = 0; d_addr = 0; d_wd = 0;
      for (int it = 0; it < 150; it++) begin
         if (!c_pend && $urandom_range(0, 1) == 1) begin
            c_pend = 1; c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wd = $urandom;
         end
         if (!d_pend && $urandom_range(0, 1) == 1) begin
            d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wd = $urandom;
         end
         if (!c_pend && !d_pend) begin
            drive_idle();
            tick();
            check("rand_idle", 32'({bus.grant, bus.mem_en}), 32'd0);
            continue;
         end
         win_dma = d_pend && (!c_pend || !m_last_dma);
         r = int'($urandom_range(0, 24));
         dly = (r == 0) ? NEVER : (r == 1) ? TIMEOUT : int'($urandom_range(0, 6));
         v = mk(c_pend, c_we, c_addr, c_wd, d_pend, d_we, d_addr, d_wd, dly, $urandom,
                win_dma ? 2'b10 : 2'b01);
         do_access(v);
         if (win_dma) d_pend = 0; else c_pend = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
